// File: rtl/packet_gen_pkg.sv
// Shared definitions for the AXI-Stream packet generator: FSM encoding and
// payload field placement within TDATA.
package packet_gen_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   localparam int PKT_IDX_OFS  = 0;
   localparam int PKT_IDX_W    = 32;
   localparam int BEAT_IDX_OFS = 32;
   localparam int BEAT_IDX_W   = 16;

endpackage

// File: rtl/packet_gen.sv
// Test-pattern packet generator: streams packet_count packets of packet_beats
// beats each, payload = {beat index, packet index}, with no bubbles.
module packet_gen
   import packet_gen_pkg::*;
#(
   parameter int DATA_WBITS = 512
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [31:0]           packet_count,
   input  logic [15:0]           packet_beats,
   input  logic                  eth_aligned,
   output logic                  busy,
   output logic [DATA_WBITS-1:0] AXIS_TX_TDATA,
   output logic                  AXIS_TX_TLAST,
   output logic                  AXIS_TX_TVALID,
   input  logic                  AXIS_TX_TREADY
);

   state_t                  r_state;
   logic [PKT_IDX_W-1:0]    r_pkt_cnt;
   logic [PKT_IDX_W-1:0]    r_pkt_idx;
   logic [BEAT_IDX_W-1:0]   r_beats;
   logic [BEAT_IDX_W-1:0]   r_beat_idx;
   logic                    r_unaligned;

   logic                    w_send;
   logic                    w_last;
   logic                    w_final_pkt;
   logic                    w_xfer;
   logic                    w_accept;
   logic [DATA_WBITS-1:0]   w_tdata;

   assign w_send      = (r_state == ST_SEND);
   assign w_last      = (r_beat_idx == r_beats - 16'd1);
   assign w_final_pkt = (r_pkt_idx == r_pkt_cnt - 32'd1);
   assign w_xfer      = w_send && AXIS_TX_TREADY;
   assign w_accept    = start && eth_aligned &&
                        (packet_count != 32'd0) && (packet_beats != 16'd0);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state     <= ST_IDLE;
         r_pkt_cnt   <= '0;
         r_pkt_idx   <= '0;
         r_beats     <= '0;
         r_beat_idx  <= '0;
         r_unaligned <= 1'b0;
      end else if (r_state == ST_IDLE) begin
         r_unaligned <= 1'b0;
         if (w_accept) begin
            r_pkt_cnt  <= packet_count;
            r_beats    <= packet_beats;
            r_pkt_idx  <= '0;
            r_beat_idx <= '0;
            r_state    <= ST_SEND;
         end
      end else begin
         // Alignment loss is remembered so the session ends at the next packet
         // boundary even if eth_aligned recovers before then.
         if (!eth_aligned)
            r_unaligned <= 1'b1;
         if (w_xfer) begin
            if (w_last) begin
               r_beat_idx <= '0;
               r_pkt_idx  <= r_pkt_idx + 32'd1;
               if (w_final_pkt || r_unaligned || !eth_aligned)
                  r_state <= ST_IDLE;
            end else begin
               r_beat_idx <= r_beat_idx + 16'd1;
            end
         end
      end
   end

   always_comb begin
      w_tdata = '0;
      if (w_send) begin
         w_tdata[PKT_IDX_OFS  +: PKT_IDX_W]  = r_pkt_idx;
         w_tdata[BEAT_IDX_OFS +: BEAT_IDX_W] = r_beat_idx;
      end
   end

   assign busy           = w_send;
   assign AXIS_TX_TVALID = w_send;
   assign AXIS_TX_TLAST  = w_send && w_last;
   assign AXIS_TX_TDATA  = w_tdata;

endmodule
